// File: rtl/ldpc_pkg.sv
// Shared constants and types for the (12,6) LDPC bit-flipping decoder.
// Each H_ROW entry is a parity check expressed as a mask over the 12 word bits.
package ldpc_pkg;

    localparam int N = 12;
    localparam int M = 6;

    // H_ROW[k] is check k; every word bit appears in exactly two rows.
    localparam logic [M-1:0][N-1:0] H_ROW = {
        12'h50C, 12'h851, 12'h2A1, 12'h462, 12'h88A, 12'h314
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EVAL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ldpc_flip_logic.sv
// Combinational syndrome and flip-mask evaluation for one 12-bit hard-decision word.
// A bit is flipped when its unsatisfied-check count equals the largest nonzero count.
module ldpc_flip_logic
    import ldpc_pkg::*;
(
    input  logic [N-1:0] word_i,
    output logic [M-1:0] syndrome_o,
    output logic [N-1:0] flip_mask_o
);

    logic [N-1:0][1:0] unsat;
    logic [1:0]        maxu;

    always_comb begin
        for (int k = 0; k < M; k++) begin
            syndrome_o[k] = ^(word_i & H_ROW[k]);
        end
    end

    // Column weight is 2, so a 2-bit count per bit cannot overflow.
    always_comb begin
        for (int b = 0; b < N; b++) begin
            unsat[b] = 2'd0;
            for (int k = 0; k < M; k++) begin
                unsat[b] = unsat[b] + 2'(syndrome_o[k] & H_ROW[k][b]);
            end
        end
    end

    always_comb begin
        maxu = 2'd0;
        for (int b = 0; b < N; b++) begin
            if (unsat[b] > maxu) maxu = unsat[b];
        end
    end

    always_comb begin
        for (int b = 0; b < N; b++) begin
            flip_mask_o[b] = (unsat[b] == maxu) && (maxu != 2'd0);
        end
    end

endmodule

// File: rtl/ldpc_bitflip_ctrl.sv
// Iterative bit-flipping decoder controller: CHECK latches syndrome and flip mask,
// EVAL either finishes or applies one flip round, DONE holds the result for the consumer.
module ldpc_bitflip_ctrl
    import ldpc_pkg::*;
#(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_word,
    output logic [M-1:0]      out_syndrome,
    output logic              out_success,
    output logic [ITER_W-1:0] out_iters
);

    if (MAX_ITER < 0 || MAX_ITER >= (2 ** ITER_W)) begin : g_bad_param
        $error("ldpc_bitflip_ctrl: MAX_ITER must lie in [0, 2**ITER_W)");
    end

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [N-1:0]      word_q, word_d;
    logic [M-1:0]      syn_q, syn_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic [M-1:0]      syn_comb;
    logic [N-1:0]      mask_comb;

    ldpc_flip_logic u_flip (
        .word_i      (word_q),
        .syndrome_o  (syn_comb),
        .flip_mask_o (mask_comb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            syn_q   <= '0;
            mask_q  <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            syn_q   <= syn_d;
            mask_q  <= mask_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        syn_d   = syn_q;
        mask_d  = mask_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    iter_d  = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                syn_d   = syn_comb;
                mask_d  = mask_comb;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (syn_q == '0 || iter_q == ITER_LIMIT) begin
                    state_d = ST_DONE;
                end else begin
                    word_d  = word_q ^ mask_q;
                    iter_d  = iter_q + 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Success is gated by DONE so that the reset/idle view reads all-zero.
    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_word     = word_q;
    assign out_syndrome = syn_q;
    assign out_success  = (state_q == ST_DONE) && (syn_q == '0);
    assign out_iters    = iter_q;

endmodule

// File: tb/tb_ldpc_bitflip_ctrl.sv
// Bench for ldpc_bitflip_ctrl: three instances (MAX_ITER 8, 1, 0) decode the same words
// and are compared against a behavioural bit-flipping model.
module tb_ldpc_bitflip_ctrl;

    localparam logic [11:0] HB [6] = '{12'h314, 12'h88A, 12'h462, 12'h2A1, 12'h851, 12'h50C};
    localparam int MAXIT [3] = '{8, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_word = '0;
    logic [2:0]  rdy, ov, osucc;
    logic [11:0] ow [3];
    logic [5:0]  os [3];
    logic [3:0]  oit [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ldpc_bitflip_ctrl #(.MAX_ITER(8), .ITER_W(4)) u_m8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_word(in_word),
        .out_valid(ov[0]), .out_ready(out_ready), .out_word(ow[0]), .out_syndrome(os[0]),
        .out_success(osucc[0]), .out_iters(oit[0]));

    ldpc_bitflip_ctrl #(.MAX_ITER(1), .ITER_W(4)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_word(in_word),
        .out_valid(ov[1]), .out_ready(out_ready), .out_word(ow[1]), .out_syndrome(os[1]),
        .out_success(osucc[1]), .out_iters(oit[1]));

    ldpc_bitflip_ctrl #(.MAX_ITER(0), .ITER_W(4)) u_m0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_word(in_word),
        .out_valid(ov[2]), .out_ready(out_ready), .out_word(ow[2]), .out_syndrome(os[2]),
        .out_success(osucc[2]), .out_iters(oit[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_syn(input logic [11:0] w);
        logic [5:0] s;
        for (int k = 0; k < 6; k++) s[k] = ($countones(w & HB[k]) % 2) == 1;
        return s;
    endfunction

    // Plain restatement of the decoding rule: flip every bit tied for most failing checks.
    task automatic ref_decode(input logic [11:0] w_in, input int maxit,
                              output logic [11:0] w, output logic [5:0] s, output int it);
        int u [12];
        int maxu;
        logic [11:0] h;
        w  = w_in;
        it = 0;
        s  = ref_syn(w);
        while (s != 0 && it < maxit) begin
            maxu = 0;
            for (int b = 0; b < 12; b++) begin
                u[b] = 0;
                for (int k = 0; k < 6; k++) begin
                    h = HB[k];
                    if (s[k] && h[b]) u[b]++;
                end
                if (u[b] > maxu) maxu = u[b];
            end
            for (int b = 0; b < 12; b++) if (maxu > 0 && u[b] == maxu) w[b] = ~w[b];
            it++;
            s = ref_syn(w);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, 32'(rdy), 32'h7);
        check({tag, " out_valid"}, 32'(ov), 32'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_idle(tag);
        check({tag, " out_success"}, 32'(osucc), 32'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s u%0d word", tag, i), 32'(ow[i]), 32'h0);
            check($sformatf("%s u%0d syn", tag, i), 32'(os[i]), 32'h0);
            check($sformatf("%s u%0d iters", tag, i), 32'(oit[i]), 32'h0);
        end
    endtask

    // Waits (bounded) for all instances idle, then returns just after the accept edge.
    task automatic send(input logic [11:0] w);
        int guard = 0;
        in_word  = w;
        in_valid = 1'b1;
        while (rdy != 3'b111 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("accept ready in=%03h", w), 32'(rdy), 32'h7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = 12'($urandom);
    endtask

    // Called just after the accept edge; cycle 1 is the first cycle after acceptance.
    task automatic collect(input logic [11:0] w);
        int lat [3];
        bit seen [3];
        int cyc = 1;
        logic [11:0] ew;
        logic [5:0]  es;
        int eit;
        for (int i = 0; i < 3; i++) begin seen[i] = 0; lat[i] = 0; end
        while (cyc <= 60) begin
            for (int i = 0; i < 3; i++) if (ov[i] && !seen[i]) begin seen[i] = 1; lat[i] = cyc; end
            if (seen[0] && seen[1] && seen[2]) break;
            @(posedge clk); #1;
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            ref_decode(w, MAXIT[i], ew, es, eit);
            check($sformatf("u%0d in=%03h valid", i, w), 32'(ov[i]), 32'h1);
            check($sformatf("u%0d in=%03h word", i, w), 32'(ow[i]), 32'(ew));
            check($sformatf("u%0d in=%03h syn", i, w), 32'(os[i]), 32'(es));
            check($sformatf("u%0d in=%03h success", i, w), 32'(osucc[i]), 32'(es == 0));
            check($sformatf("u%0d in=%03h iters", i, w), 32'(oit[i]), 32'(eit));
            check($sformatf("u%0d in=%03h latency", i, w), 32'(lat[i]), 32'(3 + 2 * eit));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        logic [11:0] w;
        logic [11:0] snap_w [3];
        logic [5:0]  snap_s [3];
        logic [3:0]  snap_i [3];
        logic [2:0]  snap_succ;

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("post-reset");

        // Clean codeword and a single error at bit 11.
        send(12'hFFF); collect(12'hFFF);
        check("clean u0 word", 32'(ow[0]), 32'hFFF);
        check("clean u0 iters", 32'(oit[0]), 32'h0);
        release_out("clean release");

        send(12'h800); collect(12'h800);
        check("single u0 word", 32'(ow[0]), 32'h000);
        check("single u0 iters", 32'(oit[0]), 32'h1);
        check("single u0 success", 32'(osucc[0]), 32'h1);
        check("maxit0 u2 word", 32'(ow[2]), 32'h800);
        check("maxit0 u2 syn", 32'(os[2]), 32'h12);
        check("maxit0 u2 success", 32'(osucc[2]), 32'h0);
        release_out("single release");

        // Double error that cannot be fixed in one round.
        send(12'hC00); collect(12'hC00);
        check("limit u1 word", 32'(ow[1]), 32'h04A);
        check("limit u1 syn", 32'(os[1]), 32'h30);
        check("limit u1 success", 32'(osucc[1]), 32'h0);
        release_out("limit release");

        // Backpressure: a pending word must wait until the result is taken.
        send(12'h800); collect(12'h800);
        in_word  = 12'hFFF;
        in_valid = 1'b1;
        snap_succ = osucc;
        for (int i = 0; i < 3; i++) begin snap_w[i] = ow[i]; snap_s[i] = os[i]; snap_i[i] = oit[i]; end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp c%0d in_ready", c), 32'(rdy), 32'h0);
            check($sformatf("bp c%0d out_valid", c), 32'(ov), 32'h7);
            check($sformatf("bp c%0d success", c), 32'(osucc), 32'(snap_succ));
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp c%0d u%0d word", c, i), 32'(ow[i]), 32'(snap_w[i]));
                check($sformatf("bp c%0d u%0d syn", c, i), 32'(os[i]), 32'(snap_s[i]));
                check($sformatf("bp c%0d u%0d iters", c, i), 32'(oit[i]), 32'(snap_i[i]));
            end
        end
        release_out("bp release");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = 12'h5A5;
        collect(12'hFFF);
        release_out("bp pending release");

        // Asynchronous reset while the controller is in CHECK.
        send(12'hC00);
        #2 rst = 1'b1;
        #1 check_zero_outputs("midreset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("after midreset");
        send(12'h800); collect(12'h800);
        check("after midreset u0 word", 32'(ow[0]), 32'h000);
        release_out("after midreset release");

        // Random words and low-weight error patterns around the all-zero codeword.
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 1) w = 12'($urandom);
            else begin
                w = 12'h001 << $urandom_range(0, 11);
                if (i % 4 == 0) w = w ^ (12'h001 << $urandom_range(0, 11));
            end
            send(w);
            collect(w);
            release_out($sformatf("rand %0d release", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
